sump_cmd_decoder: RTL and testbench
===================================

Name: sump_cmd_decoder

Overview:
- Assembles SUMP command frames from the UART receiver's byte stream.
- Presents opcode plus 32-bit argument to the analyzer controller, with a one-cycle completion strobe.
- Sits between the UART RX byte interface and the controller's opcode/command/cmd_recv_rx inputs.
- Short commands (opcode bit 7 = 0) are 1 byte. Long commands (opcode bit 7 = 1) are 5 bytes: the opcode followed by 4 argument bytes, least-significant byte first.

Parameters:
- TIMEOUT_CYCLES, 1_000_000, inter-byte idle limit in clock cycles while a long command is partially received. Used only with CMD_TIMEOUT_EN.

Ports:
- clock  input  1  system clock
- ext_reset_n  input  1  reset. One clock; reset is asynchronous and active-low.
- rx_data  input  8  received byte, valid when rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte. No backpressure; every strobe is consumed.
- rx_frame_err  input  1  UART framing/stop-bit error on the current byte. Qualified by rx_valid.
- opcode  output  8  opcode of the last completed command
- command  output  32  argument of the last completed command. 0 for short commands.
- cmd_recv_rx  output  1  one-cycle pulse: opcode/command newly valid
- cmd_abort  output  1  one-cycle pulse: a partial long command was discarded
- busy  output  1  high while in ARGS state

Behaviour:
- Reset values (async assert, sync release):
  - opcode=0x00, command=0x00000000
  - cmd_recv_rx=0, cmd_abort=0, busy=0
  - state=IDLE, byte counter=0, timeout counter=0
- States:
  - IDLE: waiting for an opcode byte.
  - ARGS: collecting argument bytes, with a 2-bit counter idx of 0..3.
- IDLE, rx_valid=1, rx_frame_err=0:
  - rx_data[7]=0: on that edge, opcode<=rx_data and command<=0. cmd_recv_rx is high the next cycle, for exactly one cycle. Stay in IDLE.
  - rx_data[7]=1: latch the byte into a pending-opcode register, clear the shadow argument, set idx=0, go to ARGS.
- ARGS, rx_valid=1, rx_frame_err=0:
  - Write shadow[8*idx +: 8] <= rx_data, then idx++.
  - When idx=3 is written: on that edge, opcode<=pending opcode and command<={rx_data, shadow[23:0]}. cmd_recv_rx pulses the next cycle. Go to IDLE.
  - Argument bytes are never interpreted as opcodes, including 0x00.
- opcode/command change only on a completion edge. They hold stable between completions, including while a new frame is being collected.
- Latency: cmd_recv_rx is asserted exactly 1 cycle after the edge that sampled the final byte.
- Back-to-back bytes: rx_valid may be high on consecutive cycles, including the cmd_recv_rx cycle. That byte is processed as the next frame's first byte, with no loss.
- Framing error:
  - In IDLE: rx_valid with rx_frame_err=1 drops the byte. No pulses.
  - In ARGS: drop the byte and the partial frame, go to IDLE, pulse cmd_abort the next cycle. opcode/command are unchanged.
- SUMP reset (five 0x00 bytes): each 0x00 received in IDLE yields its own cmd_recv_rx with opcode 0x00.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-frame discards all partial state immediately. No pulse is emitted.

Optional Feature:
- Macro: SUMP_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on every rx_valid and increments each cycle in ARGS.
  - When it reaches TIMEOUT_CYCLES-1 with no byte arriving: discard the frame, go to IDLE, pulse cmd_abort the next cycle. opcode/command are unchanged.
  - If a byte arrives on the same cycle the limit is reached, the byte wins and there is no abort.
  - The counter is held at 0 in IDLE.
- Undefined:
  - No counter is instantiated, and ARGS waits indefinitely.
  - cmd_abort is driven only by framing errors.

Test Plan:
- Byte 0x02 -> one cycle later: cmd_recv_rx=1 for 1 cycle, opcode=0x02, command=0x00000000, busy stays 0.
- Bytes 0x80,0x0F,0x00,0x00,0x00, one per 3 cycles:
  - busy=1 from the 0x80 byte until the last byte.
  - cmd_recv_rx pulses once after the 5th byte, with opcode=0x80, command=0x0000000F.
  - No pulse after bytes 1-4.
- Back-to-back strobes 0xC0,0x11,0x22,0x33,0x44,0x01 on 6 consecutive cycles:
  - Pulse with opcode=0xC0, command=0x44332211.
  - Then, on the next cycle, pulse with opcode=0x01, command=0.
- Frame-error abort:
  - Complete 0x02 first.
  - Then send 0x81,0xAA, then 0xBB with rx_frame_err=1.
  - Expect cmd_abort one pulse, state IDLE, opcode=0x02 retained.
  - A following 0x04 completes normally.
- Reset mid-frame: 0x81,0x01 sent, then ext_reset_n low for 2 cycles -> all outputs at reset values, no pulse. A subsequent 0x07 decodes correctly.
- SUMP_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - Send 0xC1 and 2 argument bytes, then idle.
  - Expect cmd_abort 16 cycles after the last byte, and no cmd_recv_rx.
  - Repeat with bytes spaced 15 cycles apart -> completes normally.

Source files
------------

// File: rtl/sump_cmd_decoder_if.sv
// SUMP command decoder bus: UART RX byte stream in, decoded command out.
// The decoder uses the slave modport; the byte source and controller use master.
interface sump_cmd_decoder_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_frame_err;
   logic [7:0]  opcode;
   logic [31:0] command;
   logic        cmd_recv_rx;
   logic        cmd_abort;
   logic        busy;

   modport master (
      output rx_data, rx_valid, rx_frame_err,
      input  opcode, command, cmd_recv_rx, cmd_abort, busy
   );

   modport slave (
      input  rx_data, rx_valid, rx_frame_err,
      output opcode, command, cmd_recv_rx, cmd_abort, busy
   );
endinterface

// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: assembles 1-byte short and 5-byte long commands
// (opcode, then 4 argument bytes LSB first) from the UART RX byte stream.
// Optional inter-byte timeout for partial long commands: define
// SUMP_CMD_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module sump_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clock,
   input  logic              ext_reset_n,
   sump_cmd_decoder_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ARGS = 1'b1;

   logic [0:0]  state;
   logic [1:0]  idx;
   logic [7:0]  pending;
   logic [23:0] shadow;     // bytes 0..2 of the argument; byte 3 goes straight out
   logic [7:0]  opcode_q;
   logic [31:0] command_q;
   logic        recv_q;
   logic        abort_q;
   logic        byte_ok;
   logic        byte_bad;
   logic        expired;

   assign byte_ok  = bus.rx_valid && !bus.rx_frame_err;
   assign byte_bad = bus.rx_valid &&  bus.rx_frame_err;

`ifdef SUMP_CMD_TIMEOUT_EN
   logic [31:0] idle_cnt;

   // A strobe on the limit cycle wins over expiry.
   assign expired = (state == ARGS) && !bus.rx_valid &&
                    (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Idle-cycle counter: held at zero in IDLE, cleared by any strobe or expiry.
   always_ff @(posedge clock or negedge ext_reset_n) begin
      if (!ext_reset_n)
         idle_cnt <= '0;
      else if (state == IDLE || bus.rx_valid || expired)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 32'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign expired        = 1'b0;
`endif

   // Frame assembly FSM; opcode/command only move on a completion edge.
   always_ff @(posedge clock or negedge ext_reset_n) begin
      if (!ext_reset_n) begin
         state     <= IDLE;
         idx       <= 2'd0;
         pending   <= 8'h00;
         shadow    <= 24'h0;
         opcode_q  <= 8'h00;
         command_q <= 32'h0;
         recv_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         recv_q  <= 1'b0;
         abort_q <= 1'b0;
         case (state)
            IDLE: begin
               if (byte_ok) begin
                  if (!bus.rx_data[7]) begin
                     opcode_q  <= bus.rx_data;
                     command_q <= 32'h0;
                     recv_q    <= 1'b1;
                  end else begin
                     pending <= bus.rx_data;
                     shadow  <= 24'h0;
                     idx     <= 2'd0;
                     state   <= ARGS;
                  end
               end
            end
            ARGS: begin
               if (byte_bad) begin
                  state   <= IDLE;
                  abort_q <= 1'b1;
               end else if (byte_ok) begin
                  // Argument bytes are stored raw, never decoded as opcodes.
                  case (idx)
                     2'd0:    shadow[7:0]   <= bus.rx_data;
                     2'd1:    shadow[15:8]  <= bus.rx_data;
                     2'd2:    shadow[23:16] <= bus.rx_data;
                     default: begin
                        opcode_q  <= pending;
                        command_q <= {bus.rx_data, shadow};
                        recv_q    <= 1'b1;
                        state     <= IDLE;
                     end
                  endcase
                  idx <= idx + 2'd1;
               end else if (expired) begin
                  state   <= IDLE;
                  abort_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.opcode      = opcode_q;
   assign bus.command     = command_q;
   assign bus.cmd_recv_rx = recv_q;
   assign bus.cmd_abort   = abort_q;
   assign bus.busy        = (state == ARGS);
endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: directed test-plan steps then random byte
// streams, checked every cycle against a frame-queue reference model.
module tb_sump_cmd_decoder;
   localparam int TO = 16;
`ifdef SUMP_CMD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic ext_reset_n = 1'b0;
   sump_cmd_decoder_if bus();

   sump_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock),
      .ext_reset_n(ext_reset_n),
      .bus(bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_err = 0;

   // reference model: bytes of the frame in progress + expected outputs
   logic [7:0]  frm[$];
   int          idle;
   logic [7:0]  e_op;
   logic [31:0] e_cmd;
   logic        e_recv, e_abort;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      frm.delete();
      idle = 0;
      e_op = 8'h00; e_cmd = 32'h0; e_recv = 1'b0; e_abort = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic fe);
      e_recv = 1'b0; e_abort = 1'b0;
      if (!ext_reset_n) begin
         model_reset();
      end else if (v && !fe) begin
         frm.push_back(d);
         idle = 0;
         if (!frm[0][7]) begin
            e_op = frm[0]; e_cmd = 32'h0; e_recv = 1'b1; frm.delete();
         end else if (frm.size() == 5) begin
            e_op = frm[0]; e_cmd = {frm[4], frm[3], frm[2], frm[1]};
            e_recv = 1'b1; frm.delete();
         end
      end else if (v && fe) begin
         if (frm.size() > 0) e_abort = 1'b1;
         frm.delete();
         idle = 0;
      end else if (TO_EN && frm.size() > 0) begin
         idle++;
         if (idle == TO) begin
            e_abort = 1'b1; frm.delete(); idle = 0;
         end
      end
   endtask

   task automatic compare_all();
      chk("cmd_recv_rx", 32'(bus.cmd_recv_rx), 32'(e_recv));
      chk("cmd_abort",   32'(bus.cmd_abort),   32'(e_abort));
      chk("busy",        32'(bus.busy),        32'(frm.size() > 0));
      chk("opcode",      32'(bus.opcode),      32'(e_op));
      chk("command",     bus.command,          e_cmd);
   endtask

   // one clock: drive inputs, advance model at the edge, compare at negedge
   task automatic tick(input logic v, input logic [7:0] d, input logic fe);
      bus.rx_valid = v; bus.rx_data = d; bus.rx_frame_err = fe;
      @(posedge clock);
      model_step(v, d, fe);
      @(negedge clock);
      compare_all();
   endtask

   task automatic send(input logic [7:0] d, input int gap);
      tick(1'b1, d, 1'b0);
      for (int g = 0; g < gap; g++) tick(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      int first_abort;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_frame_err = 1'b0;
      model_reset();
      @(negedge clock);
      compare_all();
      chk("reset_busy", 32'(bus.busy), 32'd0);
      @(negedge clock);
      ext_reset_n = 1'b1;
      tick(1'b0, 8'h00, 1'b0);

      // short command
      tick(1'b1, 8'h02, 1'b0);
      chk("short_recv", 32'(bus.cmd_recv_rx), 32'd1);
      chk("short_op", 32'(bus.opcode), 32'h02);
      tick(1'b0, 8'h00, 1'b0);
      chk("short_pulse_len", 32'(bus.cmd_recv_rx), 32'd0);

      // long command, one byte per 3 cycles
      send(8'h80, 2); send(8'h0F, 2); send(8'h00, 2); send(8'h00, 2);
      chk("long_busy", 32'(bus.busy), 32'd1);
      tick(1'b1, 8'h00, 1'b0);
      chk("long_cmd", bus.command, 32'h0000000F);
      chk("long_op", 32'(bus.opcode), 32'h80);
      send(8'h00, 2);

      // back-to-back long then short
      send(8'hC0, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
      tick(1'b1, 8'h44, 1'b0);
      chk("b2b_cmd", bus.command, 32'h44332211);
      tick(1'b1, 8'h01, 1'b0);
      chk("b2b_short", 32'(bus.opcode), 32'h01);
      chk("b2b_recv", 32'(bus.cmd_recv_rx), 32'd1);

      // framing error abort
      send(8'h02, 1); send(8'h81, 1); send(8'hAA, 1);
      tick(1'b1, 8'hBB, 1'b1);
      chk("ferr_abort", 32'(bus.cmd_abort), 32'd1);
      chk("ferr_op_kept", 32'(bus.opcode), 32'h02);
      tick(1'b0, 8'h00, 1'b0);
      chk("ferr_idle", 32'(bus.busy), 32'd0);
      send(8'h04, 0);
      chk("after_ferr_op", 32'(bus.opcode), 32'h04);
      send(8'h00, 1);

      // reset mid-frame
      send(8'h81, 1); send(8'h01, 1);
      ext_reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_op", 32'(bus.opcode), 32'h00);
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      ext_reset_n = 1'b1;
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b1, 8'h07, 1'b0);
      chk("post_rst_op", 32'(bus.opcode), 32'h07);
      send(8'h00, 1);

      // timeout: abort 16 cycles after the last byte / spaced 15 completes
      if (TO_EN) begin
         send(8'hC1, 0); send(8'h01, 0); tick(1'b1, 8'h02, 1'b0);
         first_abort = 0;
         for (int k = 1; k <= TO + 4; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (bus.cmd_abort && first_abort == 0) first_abort = k;
         end
         chk("timeout_at", 32'(first_abort), 32'(TO));
         send(8'hC1, 14); send(8'h01, 14); send(8'h02, 14); send(8'h03, 14);
         tick(1'b1, 8'h04, 1'b0);
         chk("spaced_cmd", bus.command, 32'h04030201);
         chk("spaced_recv", 32'(bus.cmd_recv_rx), 32'd1);
         // byte on the exact expiry cycle wins
         send(8'hC2, TO - 1);
         tick(1'b1, 8'h55, 1'b0);
         chk("limit_byte_wins", 32'(bus.cmd_abort), 32'd0);
         send(8'h00, 0); send(8'h00, 0); send(8'h00, 2);
      end

      // random streams
      for (int i = 0; i < 400; i++) begin
         logic [7:0] b;
         logic fe;
         int gap;
         b = 8'($urandom);
         if ($urandom_range(0, 2) == 0) b[7] = 1'b1;
         fe = ($urandom_range(0, 15) == 0);
         gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                           : int'($urandom_range(0, 3));
         tick(1'b1, b, fe);
         for (int g = 0; g < gap; g++) tick(1'b0, 8'h00, 1'b0);
      end
      for (int g = 0; g < TO + 2; g++) tick(1'b0, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
